// File: rtl/ex_pkg.sv
// ============================================================================
// Module   : ex_pkg
// Brief    : Shared constants and types for the execute stage: datapath and
//            control widths, control-bundle bit positions, FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 22;

    // Control-bundle bit positions
    localparam int c_IS_LD   = 0;
    localparam int c_IS_ST   = 1;
    localparam int c_IS_BEQ  = 2;
    localparam int c_IS_BGT  = 3;
    localparam int c_IS_RET  = 4;
    localparam int c_IS_IMM  = 5;
    localparam int c_IS_WB   = 6;
    localparam int c_IS_UBR  = 7;
    localparam int c_IS_CALL = 8;
    localparam int c_ADD     = 9;
    localparam int c_SUB     = 10;
    localparam int c_CMP     = 11;
    localparam int c_MUL     = 12;
    localparam int c_DIV     = 13;
    localparam int c_MOD     = 14;
    localparam int c_LSL     = 15;
    localparam int c_LSR     = 16;
    localparam int c_ASR     = 17;
    localparam int c_OR      = 18;
    localparam int c_AND     = 19;
    localparam int c_NOT     = 20;
    localparam int c_MOV     = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } ex_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_divider.sv
// ============================================================================
// Module   : ex_divider
// Brief    : Iterative restoring signed divider, one quotient bit per cycle.
//            i_start captures the operands; o_busy is high while iterating;
//            o_done stays high from completion until the next i_start.
//            Divide by zero gives quotient all-ones and remainder = dividend;
//            most-negative / -1 gives quotient most-negative, remainder 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_divider
    import ex_pkg::*;
#(
    parameter int DIV_CYCLES = XLEN
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int              c_CW   = $clog2(DIV_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV_CYCLES - 1);
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] r_rem, r_quo, r_dvs, r_dividend;
    logic [c_CW-1:0] r_cnt;
    logic            r_busy, r_done, r_neg_q, r_neg_r, r_dz, r_ovf;

    logic [XLEN-1:0] w_abs_a, w_abs_b, w_q_s, w_r_s;
    logic [XLEN:0]   w_rem_sh, w_diff;

    // Operand magnitudes and the trial subtraction of one restoring step
    always_comb begin
        w_abs_a  = i_dividend[XLEN-1] ? (~i_dividend + 1'b1) : i_dividend;
        w_abs_b  = i_divisor[XLEN-1]  ? (~i_divisor  + 1'b1) : i_divisor;
        w_rem_sh = {r_rem, r_quo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_dvs};
    end

    // Operand capture on start, then one shift/subtract step per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (i_start) begin
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_dvs      <= w_abs_b;
            r_dividend <= i_dividend;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_neg_q    <= i_dividend[XLEN-1] ^ i_divisor[XLEN-1];
            r_neg_r    <= i_dividend[XLEN-1];
            r_dz       <= (i_divisor == '0);
            r_ovf      <= (i_dividend == c_MIN) && (i_divisor == '1);
        end else if (r_busy) begin
            r_rem <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
            r_cnt <= r_cnt + c_CW'(1);
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // Sign restoration and the two special-case overrides
    always_comb begin
        w_q_s = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_r_s = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        if (r_dz) begin
            o_quotient  = '1;
            o_remainder = r_dividend;
        end else if (r_ovf) begin
            o_quotient  = c_MIN;
            o_remainder = '0;
        end else begin
            o_quotient  = w_q_s;
            o_remainder = w_r_s;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module   : ex_stage
// Brief    : Pipeline execute stage: ALU, compare flags, branch resolution
//            and the EX/MA output register. Build option EX_DIV_EN adds a
//            multi-cycle signed divide/modulo with upstream stall; without
//            it div/mod complete in one cycle with a zero result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
    import ex_pkg::*;
`ifdef EX_DIV_EN
#(
    parameter int DIV_CYCLES = XLEN
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   pc_EX_in,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2_in,
    input  logic [XLEN-1:0]   immx,
    input  logic [XLEN-1:0]   branchTarget_in,
    input  logic [XLEN-1:0]   inst_in_of,
    input  logic [CTRL_W-1:0] control_signals_of,
    output logic              stall_ex,
    output logic [XLEN-1:0]   pc_EX_out,
    output logic [XLEN-1:0]   aluResult,
    output logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   inst_out_ex,
    output logic [CTRL_W-1:0] control_signals_ex,
    output logic [XLEN-1:0]   branchPC_EX,
    output logic              isBranchTaken_EX
);

    logic [XLEN-1:0]   r_pc, r_alu, r_op2, r_inst, r_bpc;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_taken, r_flag_e, r_flag_gt;

    logic [XLEN-1:0]   w_b, w_alu, w_bpc, w_div_res;
    logic [4:0]        w_sh;
    logic              w_taken, w_is_divop, w_load_inst, w_load_div, w_stall;

    // Operand select, ALU result, branch decision and target
    always_comb begin
        w_b        = control_signals_of[c_IS_IMM] ? immx : op2_in;
        w_sh       = w_b[4:0];
        w_is_divop = control_signals_of[c_DIV] | control_signals_of[c_MOD];
        w_alu      = '0;
        if (control_signals_of[c_ADD])      w_alu = op1 + w_b;
        else if (control_signals_of[c_SUB]) w_alu = op1 - w_b;
        else if (control_signals_of[c_MUL]) w_alu = op1 * w_b;
        else if (control_signals_of[c_LSL]) w_alu = op1 << w_sh;
        else if (control_signals_of[c_LSR]) w_alu = op1 >> w_sh;
        else if (control_signals_of[c_ASR]) w_alu = $unsigned($signed(op1) >>> w_sh);
        else if (control_signals_of[c_OR])  w_alu = op1 | w_b;
        else if (control_signals_of[c_AND]) w_alu = op1 & w_b;
        else if (control_signals_of[c_NOT]) w_alu = ~w_b;
        else if (control_signals_of[c_MOV]) w_alu = w_b;
        w_taken = control_signals_of[c_IS_UBR]
                | (control_signals_of[c_IS_BEQ] & r_flag_e)
                | (control_signals_of[c_IS_BGT] & r_flag_gt);
        w_bpc   = control_signals_of[c_IS_RET] ? op1 : branchTarget_in;
    end

`ifdef EX_DIV_EN
    localparam int              c_CW   = $clog2(DIV_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV_CYCLES - 1);

    ex_state_t       r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic            r_stall, w_div_start, w_div_busy, w_div_done;
    logic [XLEN-1:0] w_quo, w_rem;

    ex_divider #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_dividend  (op1),
        .i_divisor   (w_b),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Next-state logic: divide accepted in IDLE, DIV_CYCLES iterations, one result cycle
    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_load_div  = 1'b0;
        w_load_inst = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in && w_is_divop) begin
                    w_div_start = 1'b1;
                    w_state_nxt = DIV;
                end else begin
                    w_load_inst = valid_in;
                end
            end
            DIV: begin
                if (r_cnt == c_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_load_div  = w_div_done & ~w_div_busy;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_div_res = control_signals_of[c_MOD] ? w_rem : w_quo;
    end

    // State register, iteration counter and registered stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == DIV) ? r_cnt + c_CW'(1) : '0;
            r_stall <= (w_state_nxt != IDLE);
        end
    end

    assign w_stall = r_stall;
`else
    // No divider: every valid instruction, div/mod included, completes in one cycle
    always_comb begin
        w_load_inst = valid_in;
        w_load_div  = 1'b0;
        w_div_res   = '0;
        w_stall     = 1'b0;
    end
`endif

    // Compare flags, written only by an accepted cmp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flag_e  <= 1'b0;
            r_flag_gt <= 1'b0;
        end else if (w_load_inst && control_signals_of[c_CMP]) begin
            r_flag_e  <= (op1 == w_b);
            r_flag_gt <= ($signed(op1) > $signed(w_b));
        end
    end

    // EX/MA register: instruction result, divide result, or bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= '0;
            r_alu   <= '0;
            r_op2   <= '0;
            r_inst  <= '0;
            r_ctrl  <= '0;
            r_bpc   <= '0;
            r_taken <= 1'b0;
        end else if (w_load_inst || w_load_div) begin
            r_pc    <= pc_EX_in;
            r_alu   <= w_load_div ? w_div_res : w_alu;
            r_op2   <= op2_in;
            r_inst  <= inst_in_of;
            r_ctrl  <= control_signals_of;
            r_bpc   <= w_bpc;
            r_taken <= w_load_inst & w_taken;
        end else begin
            r_pc    <= '0;
            r_alu   <= '0;
            r_op2   <= '0;
            r_inst  <= '0;
            r_ctrl  <= '0;
            r_bpc   <= '0;
            r_taken <= 1'b0;
        end
    end

    assign stall_ex           = w_stall;
    assign pc_EX_out          = r_pc;
    assign aluResult          = r_alu;
    assign op2                = r_op2;
    assign inst_out_ex        = r_inst;
    assign control_signals_ex = r_ctrl;
    assign branchPC_EX        = r_bpc;
    assign isBranchTaken_EX   = r_taken;

endmodule

`default_nettype wire
